// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the default operand width and
//   the FSM state encoding used by the top-level controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit
//   Single-bit gate-level full adder, the addition twin of the full-subtractor
//   cell. The bit-serial adder reuses one instance of it for every bit.
// Ports
//   s    out  1  sum bit
//   cout out  1  carry out
//   a    in   1  operand A bit
//   b    in   1  operand B bit
//   cin  in   1  carry in
module full_adder_bit (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p;
  logic g;
  logic t;

  // Propagate/generate form: s = a^b^cin, cout = ab | (a^b)cin.
  xor x_prop (p, a, b);
  xor x_sum  (s, p, cin);
  and a_gen  (g, a, b);
  and a_prop (t, p, cin);
  or  o_cout (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. Operands are captured on an accepted start and
//   added LSB first, one bit per clock, through a single full-adder cell. The
//   WIDTH+1-bit result is registered as the FSM enters DONE and is flagged by a
//   one-cycle done pulse.
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        load a,b and begin an addition (accepted in IDLE/DONE)
//   a      in   WIDTH    operand A
//   b      in   WIDTH    operand B
//   busy   out  1        high while bits are being processed
//   done   out  1        one-cycle pulse, sum valid
//   sum    out  WIDTH+1  {carry, sum bits}, held until the next result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             carry;
  logic             load;
  logic             fa_s;
  logic             fa_c;

  full_adder_bit u_fa (
    .s    (fa_s),
    .cout (fa_c),
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE accepts a new start just like IDLE so back-to-back operations lose no cycle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SHIFT;
          load       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (count == LAST) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_state = ST_SHIFT;
          load       = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // On the last shift the new carry and sum bit are not in carry/acc yet, so
  // the result is assembled straight from the adder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
      sum   <= '0;
    end else if (load) begin
      ra    <= a;
      rb    <= b;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
    end else if (state == ST_SHIFT) begin
      acc   <= {fa_s, acc[WIDTH-1:1]};
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      carry <= fa_c;
      count <= count + CW'(1);
      if (count == LAST) begin
        sum <= {fa_c, fa_s, acc[WIDTH-1:1]};
      end
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
